// File: rtl/ir_nec_pkg.sv
// Shared types and timing constants for the NEC IR frame decoder.
// All timing windows are inclusive and expressed in microseconds.
package ir_nec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD_L,
        ST_LEAD_H,
        ST_BIT_L,
        ST_BIT_H,
        ST_STOP,
        ST_RPT_STOP,
        ST_ERR
    } nec_state_e;

    localparam int unsigned WIDTH_W = 16;

    localparam int unsigned LEAD_L_MIN_US = 8000;
    localparam int unsigned LEAD_L_MAX_US = 10000;
    localparam int unsigned LEAD_H_MIN_US = 4000;
    localparam int unsigned LEAD_H_MAX_US = 5000;
    localparam int unsigned RPT_H_MIN_US  = 1800;
    localparam int unsigned RPT_H_MAX_US  = 2700;
    // Mark burst used by data bits, the stop burst and the repeat burst.
    localparam int unsigned BURST_MIN_US  = 400;
    localparam int unsigned BURST_MAX_US  = 800;
    localparam int unsigned ZERO_MIN_US   = 300;
    localparam int unsigned ZERO_MAX_US   = 800;
    localparam int unsigned ONE_MIN_US    = 1300;
    localparam int unsigned ONE_MAX_US    = 2000;

    localparam int unsigned TIMEOUT_US_DEF = 10000;

    localparam int unsigned BYTE_ADDR  = 0;
    localparam int unsigned BYTE_CMD   = 2;
    localparam int unsigned BYTE_CMD_N = 3;

    function automatic logic in_window(input logic [WIDTH_W-1:0] w,
                                       input logic [WIDTH_W-1:0] lo,
                                       input logic [WIDTH_W-1:0] hi);
        return (w >= lo) && (w <= hi);
    endfunction

    function automatic logic [7:0] get_byte(input logic [31:0] w, input int unsigned idx);
        return 8'(w >> (8 * idx));
    endfunction

endpackage

// File: rtl/ir_nec_decoder_if.sv
// Decoded-frame handshake between the NEC decoder (master) and its consumer (slave).
interface ir_nec_decoder_if;
    logic       data_valid;
    logic       data_ready;
    logic [7:0] addr;
    logic [7:0] cmd;

    modport master (output data_valid, output addr, output cmd, input data_ready);
    modport slave  (input data_valid, input addr, input cmd, output data_ready);
endinterface

// File: rtl/ir_pulse_timer.sv
// IR pin front end: tick prescaler, 2-flop synchronizer, registered edge detect and a
// saturating tick counter measuring the time since the last synced edge.
module ir_pulse_timer
    import ir_nec_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               irda,
    output logic               irda_s,
    output logic               rise,
    output logic               fall,
    output logic [WIDTH_W-1:0] width_us
);
    localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [DIV_W-1:0]   r_div;
    logic               w_tick;
    logic               r_s1, r_s2, r_s3;
    logic               r_rise, r_fall;
    logic [WIDTH_W-1:0] r_cnt;

    assign w_tick = (r_div == DIV_W'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= '0;
        end else begin
            r_div <= w_tick ? '0 : r_div + DIV_W'(1);
        end
    end

    // Sync flops reset to the idle-high level so reset release never fakes an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1   <= 1'b1;
            r_s2   <= 1'b1;
            r_s3   <= 1'b1;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_s1   <= irda;
            r_s2   <= r_s1;
            r_s3   <= r_s2;
            r_rise <= r_s2 & ~r_s3;
            r_fall <= ~r_s2 & r_s3;
        end
    end

    // Cleared the cycle after an edge is flagged, so width_us holds the full phase width
    // in the cycle where rise/fall is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_rise || r_fall) begin
            r_cnt <= '0;
        end else if (w_tick && (r_cnt != '1)) begin
            r_cnt <= r_cnt + WIDTH_W'(1);
        end
    end

    assign irda_s   = r_s3;
    assign rise     = r_rise;
    assign fall     = r_fall;
    assign width_us = r_cnt;

endmodule

// File: rtl/ir_nec_decoder.sv
// NEC IR frame decoder: leader / 32 data bits / stop sequencing by pulse width, cmd check,
// valid/ready output. Define IR_REPEAT_EN to add the rpt port and repeat-code handling.
module ir_nec_decoder
    import ir_nec_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 50,
    parameter int unsigned TIMEOUT_US = TIMEOUT_US_DEF,
    // Divides every timing window; 1 gives real NEC timing.
    parameter int unsigned TIME_SCALE = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                irda,
    ir_nec_decoder_if.master    bus,
    output logic                frame_err,
    output logic                overrun,
    output logic                busy
`ifdef IR_REPEAT_EN
    ,
    output logic                rpt
`endif
);
    localparam logic [WIDTH_W-1:0] LL_MIN = WIDTH_W'(LEAD_L_MIN_US / TIME_SCALE);
    localparam logic [WIDTH_W-1:0] LL_MAX = WIDTH_W'(LEAD_L_MAX_US / TIME_SCALE);
    localparam logic [WIDTH_W-1:0] LH_MIN = WIDTH_W'(LEAD_H_MIN_US / TIME_SCALE);
    localparam logic [WIDTH_W-1:0] LH_MAX = WIDTH_W'(LEAD_H_MAX_US / TIME_SCALE);
    localparam logic [WIDTH_W-1:0] BU_MIN = WIDTH_W'(BURST_MIN_US / TIME_SCALE);
    localparam logic [WIDTH_W-1:0] BU_MAX = WIDTH_W'(BURST_MAX_US / TIME_SCALE);
    localparam logic [WIDTH_W-1:0] B0_MIN = WIDTH_W'(ZERO_MIN_US / TIME_SCALE);
    localparam logic [WIDTH_W-1:0] B0_MAX = WIDTH_W'(ZERO_MAX_US / TIME_SCALE);
    localparam logic [WIDTH_W-1:0] B1_MIN = WIDTH_W'(ONE_MIN_US / TIME_SCALE);
    localparam logic [WIDTH_W-1:0] B1_MAX = WIDTH_W'(ONE_MAX_US / TIME_SCALE);
    localparam logic [WIDTH_W-1:0] TO_LIM = WIDTH_W'(TIMEOUT_US / TIME_SCALE);
`ifdef IR_REPEAT_EN
    localparam logic [WIDTH_W-1:0] RH_MIN = WIDTH_W'(RPT_H_MIN_US / TIME_SCALE);
    localparam logic [WIDTH_W-1:0] RH_MAX = WIDTH_W'(RPT_H_MAX_US / TIME_SCALE);
`endif

    logic               w_irda_s;
    logic               w_rise;
    logic               w_fall;
    logic [WIDTH_W-1:0] w_width;

    nec_state_e  r_state, w_state_nxt;
    logic [4:0]  r_bit_cnt;
    logic [31:0] r_shift;
    logic        w_err, w_commit, w_shift_en, w_bit_val, w_clr_frame, w_accept;
    logic [7:0]  w_byte_addr, w_byte_cmd, w_byte_cmd_n;
    logic        r_valid, r_frame_err, r_overrun, r_busy;
    logic [7:0]  r_addr, r_cmd;
`ifdef IR_REPEAT_EN
    logic        w_rpt_hit;
    logic        r_rpt;
    logic        r_have_frame;
`endif

    ir_pulse_timer #(.TICK_DIV(TICK_DIV)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .irda     (irda),
        .irda_s   (w_irda_s),
        .rise     (w_rise),
        .fall     (w_fall),
        .width_us (w_width)
    );

    assign w_byte_addr  = get_byte(r_shift, BYTE_ADDR);
    assign w_byte_cmd   = get_byte(r_shift, BYTE_CMD);
    assign w_byte_cmd_n = get_byte(r_shift, BYTE_CMD_N);
    assign w_accept     = r_valid & bus.data_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus one-cycle event strobes; any error funnels through ST_ERR.
    always_comb begin
        w_state_nxt = r_state;
        w_err       = 1'b0;
        w_commit    = 1'b0;
        w_shift_en  = 1'b0;
        w_bit_val   = 1'b0;
        w_clr_frame = 1'b0;
`ifdef IR_REPEAT_EN
        w_rpt_hit   = 1'b0;
`endif
        if ((r_state != ST_IDLE) && (r_state != ST_ERR) && (w_width > TO_LIM)) begin
            w_err = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_fall && !w_irda_s) w_state_nxt = ST_LEAD_L;
                end
                ST_LEAD_L: begin
                    if (w_rise) begin
                        if (in_window(w_width, LL_MIN, LL_MAX)) w_state_nxt = ST_LEAD_H;
                        else                                    w_err = 1'b1;
                    end
                end
                ST_LEAD_H: begin
                    if (w_fall) begin
                        if (in_window(w_width, LH_MIN, LH_MAX)) begin
                            w_state_nxt = ST_BIT_L;
                            w_clr_frame = 1'b1;
`ifdef IR_REPEAT_EN
                        end else if (in_window(w_width, RH_MIN, RH_MAX)) begin
                            w_state_nxt = ST_RPT_STOP;
`endif
                        end else begin
                            w_err = 1'b1;
                        end
                    end
                end
                ST_BIT_L: begin
                    if (w_rise) begin
                        if (in_window(w_width, BU_MIN, BU_MAX)) w_state_nxt = ST_BIT_H;
                        else                                    w_err = 1'b1;
                    end
                end
                ST_BIT_H: begin
                    if (w_fall) begin
                        if (in_window(w_width, B0_MIN, B0_MAX)) begin
                            w_shift_en = 1'b1;
                        end else if (in_window(w_width, B1_MIN, B1_MAX)) begin
                            w_shift_en = 1'b1;
                            w_bit_val  = 1'b1;
                        end else begin
                            w_err = 1'b1;
                        end
                        if (w_shift_en) begin
                            w_state_nxt = (r_bit_cnt == 5'd31) ? ST_STOP : ST_BIT_L;
                        end
                    end
                end
                ST_STOP: begin
                    if (w_rise) begin
                        if (in_window(w_width, BU_MIN, BU_MAX) && (w_byte_cmd == ~w_byte_cmd_n)) begin
                            w_commit    = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_err = 1'b1;
                        end
                    end
                end
                ST_RPT_STOP: begin
                    if (w_rise) begin
`ifdef IR_REPEAT_EN
                        if (in_window(w_width, BU_MIN, BU_MAX) && r_have_frame) begin
                            w_rpt_hit   = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_err = 1'b1;
                        end
`else
                        w_err = 1'b1;
`endif
                    end
                end
                ST_ERR:  w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
        if (w_err) w_state_nxt = ST_ERR;
    end

    // Bits arrive LSB first, so after 32 shifts byte 0 sits in r_shift[7:0].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else begin
            if (w_err || w_clr_frame) begin
                r_shift <= '0;
            end else if (w_shift_en) begin
                r_shift <= {w_bit_val, r_shift[31:1]};
            end
            if (w_err || w_clr_frame) begin
                r_bit_cnt <= '0;
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
            end
        end
    end

    // A commit coinciding with an accept refills the slot; otherwise a full slot drops it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_addr      <= '0;
            r_cmd       <= '0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            if (w_commit && (!r_valid || w_accept)) begin
                r_valid <= 1'b1;
                r_addr  <= w_byte_addr;
                r_cmd   <= w_byte_cmd;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end
            r_overrun   <= w_commit && r_valid && !w_accept;
            r_frame_err <= w_err;
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

`ifdef IR_REPEAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rpt        <= 1'b0;
            r_have_frame <= 1'b0;
        end else begin
            r_rpt <= w_rpt_hit;
            if (w_err)         r_have_frame <= 1'b0;
            else if (w_commit) r_have_frame <= 1'b1;
        end
    end

    assign rpt = r_rpt;
`endif

    assign bus.data_valid = r_valid;
    assign bus.addr       = r_addr;
    assign bus.cmd        = r_cmd;
    assign frame_err      = r_frame_err;
    assign overrun        = r_overrun;
    assign busy           = r_busy;

endmodule

// File: tb/tb_ir_nec_decoder.sv
// Scoreboard bench for ir_nec_decoder with accelerated timing (1 tick per clk, windows / 100).
module tb_ir_nec_decoder;

    localparam int T_LEAD_L = 90;
    localparam int T_LEAD_H = 45;
    localparam int T_RPT_H  = 22;
    localparam int T_BURST  = 6;
    localparam int T_ZERO   = 6;
    localparam int T_ONE    = 17;
    localparam int T_BADBIT = 10;
    localparam int T_GAP    = 25;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic irda = 1'b1;
    logic frame_err, overrun, busy;
`ifdef IR_REPEAT_EN
    logic rpt;
`endif

    ir_nec_decoder_if bus ();

    ir_nec_decoder #(.TICK_DIV(1), .TIMEOUT_US(10000), .TIME_SCALE(100)) dut (
        .clk       (clk),
        .rst       (rst),
        .irda      (irda),
        .bus       (bus),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
`ifdef IR_REPEAT_EN
        ,
        .rpt       (rpt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_ferr   = 0;
    int n_ovr    = 0;
    int n_rpt    = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected frame per valid&ready transfer and counts event pulses.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.data_valid && bus.data_ready) begin : xfer
                    logic [15:0] e;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_frame: got addr %02h cmd %02h expected none",
                                 bus.addr, bus.cmd);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_addr", 32'(bus.addr), 32'(e[15:8]));
                        check("frame_cmd", 32'(bus.cmd), 32'(e[7:0]));
                    end
                end
                if (frame_err) n_ferr++;
                if (overrun)   n_ovr++;
`ifdef IR_REPEAT_EN
                if (rpt)       n_rpt++;
`endif
            end
        end
    end

    task automatic hold(input logic lvl, input int n);
        irda = lvl;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_lead();
        hold(1'b0, T_LEAD_L);
        hold(1'b1, T_LEAD_H);
    endtask

    task automatic send_bits(input logic [31:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            hold(1'b0, T_BURST);
            hold(1'b1, w[i] ? T_ONE : T_ZERO);
        end
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        send_lead();
        send_bits({b3, b2, b1, b0}, 32);
        hold(1'b0, T_BURST);
        hold(1'b1, T_GAP);
    endtask

    task automatic send_repeat();
        hold(1'b0, T_LEAD_L);
        hold(1'b1, T_RPT_H);
        hold(1'b0, T_BURST);
        hold(1'b1, T_GAP);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        hold(1'b1, 4);
        rst = 1'b0;
        hold(1'b1, 4);
    endtask

    task automatic end_test(input string name, input int e_ferr, input int e_ovr, input int e_rpt);
        check({name, "_frame_err_cnt"}, 32'(n_ferr), 32'(e_ferr));
        check({name, "_overrun_cnt"}, 32'(n_ovr), 32'(e_ovr));
        check({name, "_rpt_cnt"}, 32'(n_rpt), 32'(e_rpt));
        check({name, "_pending_frames"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        n_ferr = 0;
        n_ovr  = 0;
        n_rpt  = 0;
    endtask

    initial begin
        bus.data_ready = 1'b1;
        hold(1'b1, 3);
        check("rst_valid", 32'(bus.data_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        hold(1'b1, 4);
        check("idle_valid", 32'(bus.data_valid), 32'd0);
        check("idle_addr", 32'(bus.addr), 32'd0);
        check("idle_cmd", 32'(bus.cmd), 32'd0);
        check("idle_frame_err", 32'(frame_err), 32'd0);
        check("idle_overrun", 32'(overrun), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // Basic frame, consumer always ready
        exp_q.push_back(16'h0045);
        send_frame(8'h00, 8'hFF, 8'h45, 8'hBA);
        check("t1_valid_after", 32'(bus.data_valid), 32'd0);
        end_test("t1", 0, 0, 0);

        // Extended NEC: byte1 is not the address inverse but must be accepted
        exp_q.push_back(16'hA581);
        send_frame(8'hA5, 8'h12, 8'h81, 8'h7E);
        end_test("t1b", 0, 0, 0);

        // Bad command inverse
        send_frame(8'h10, 8'hEF, 8'h45, 8'hBB);
        check("t2_valid", 32'(bus.data_valid), 32'd0);
        end_test("t2", 1, 0, 0);

        // Consumer stalled: second frame overruns, first held until accepted
        bus.data_ready = 1'b0;
        exp_q.push_back(16'h0016);
        send_frame(8'h00, 8'hFF, 8'h16, 8'hE9);
        check("t3_valid_first", 32'(bus.data_valid), 32'd1);
        check("t3_cmd_first", 32'(bus.cmd), 32'h16);
        send_frame(8'h00, 8'hFF, 8'h19, 8'hE6);
        check("t3_valid_held", 32'(bus.data_valid), 32'd1);
        check("t3_addr_held", 32'(bus.addr), 32'h00);
        check("t3_cmd_held", 32'(bus.cmd), 32'h16);
        bus.data_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t3_valid_drop", 32'(bus.data_valid), 32'd0);
        hold(1'b1, 3);
        end_test("t3", 0, 1, 0);

        // Reset in mid-frame, then a clean frame
        send_lead();
        send_bits(32'hF30CDF20, 11);
        check("t4_busy_mid", 32'(busy), 32'd1);
        rst = 1'b1;
        hold(1'b1, 5);
        check("t4_rst_busy", 32'(busy), 32'd0);
        check("t4_rst_valid", 32'(bus.data_valid), 32'd0);
        rst = 1'b0;
        hold(1'b1, 10);
        exp_q.push_back(16'h200C);
        send_frame(8'h20, 8'hDF, 8'h0C, 8'hF3);
        end_test("t4", 0, 0, 0);

        // Timeout on an overlong low, then a short glitch
        hold(1'b0, 120);
        hold(1'b1, T_GAP);
        check("t5_busy_after_to", 32'(busy), 32'd0);
        end_test("t5a", 1, 0, 0);
        hold(1'b0, 3);
        hold(1'b1, T_GAP);
        check("t5_valid_glitch", 32'(bus.data_valid), 32'd0);
        end_test("t5b", 1, 0, 0);

        // Data bit space between the 0 and 1 windows
        send_lead();
        send_bits(32'h00000005, 3);
        hold(1'b0, T_BURST);
        hold(1'b1, T_BADBIT);
        hold(1'b0, T_BURST);
        hold(1'b1, T_GAP);
        end_test("t5c", 1, 0, 0);

        // Repeat code handling
`ifdef IR_REPEAT_EN
        do_reset();
        send_repeat();
        end_test("t6a", 1, 0, 0);
        exp_q.push_back(16'h0045);
        send_frame(8'h00, 8'hFF, 8'h45, 8'hBA);
        send_repeat();
        check("t6_valid", 32'(bus.data_valid), 32'd0);
        end_test("t6b", 0, 0, 1);
`else
        do_reset();
        send_repeat();
        end_test("t6", 1, 0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
